// File: rtl/countdown_timer.sv
// Loadable, prescaled down-counter: counts a loaded value down to zero at TICK_HZ,
// with stop/resume, and pulses tick on every decrement and done on reaching zero.
module countdown_timer #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000,
  parameter int WIDTH   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             paused,
  output logic             tick,
  output logic             done
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_e;

  state_e           r_state, w_state;
  logic [WIDTH-1:0] r_count, w_count;
  logic [PW-1:0]    r_presc, w_presc;
  logic             r_tick, w_tick;
  logic             r_done, w_done;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    w_state = r_state;
    w_count = r_count;
    w_presc = r_presc;
    w_tick  = 1'b0;
    w_done  = 1'b0;
    if (load) begin
      w_count = load_value;
      w_presc = '0;
      w_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && (r_count != '0)) begin
            w_state = S_RUN;
            w_presc = '0;
          end
        end
        S_RUN: begin
          // The stop edge still advances the prescaler; only later edges are frozen.
          if (r_presc == PRESC_LAST) begin
            w_presc = '0;
            w_count = r_count - 1'b1;
            w_tick  = 1'b1;
            if (r_count == WIDTH'(1)) begin
              w_done  = 1'b1;
              w_state = S_IDLE;
            end
          end else begin
            w_presc = r_presc + 1'b1;
          end
          if (stop && !w_done) w_state = S_PAUSED;
        end
        S_PAUSED: begin
          if (start && !stop) w_state = S_RUN;
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_count <= w_count;
      r_presc <= w_presc;
      r_tick  <= w_tick;
      r_done  <= w_done;
    end
  end

  assign count   = r_count;
  assign running = (r_state == S_RUN);
  assign paused  = (r_state == S_PAUSED);
  assign tick    = r_tick;
  assign done    = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer (PRESCALE=10, WIDTH=8): expected ticks are
// queued with their cycle, count and done; a monitor pops them as the DUT ticks.
module tb_countdown_timer;

  localparam int P = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_value = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] count;
  logic       running, paused, tick, done;

  countdown_timer #(.CLK_HZ(10), .TICK_HZ(1), .WIDTH(8)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .count(count), .running(running),
    .paused(paused), .tick(tick), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int cnt;
    int dn;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ticks(input int t_first, input int cnt_before, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.cyc = t_first + i * P;
      e.cnt = cnt_before - 1 - i;
      e.dn  = (e.cnt == 0) ? 1 : 0;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: outputs after edge k are sampled at the following negedge, when cyc==k.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      exp_t m;
      m = exp_q.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL missed_tick: none at cycle %0d, expected count %0d", m.cyc, m.cnt);
    end
    if (tick) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_tick: tick at cycle %0d count %0d, expected none", cyc, count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("tick_cycle", cyc, e.cyc);
        check("tick_count", int'(count), e.cnt);
        check("tick_done", int'(done), e.dn);
        if (e.dn != 0) check("running_at_done", int'(running), 0);
      end
    end else if (done) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_without_tick: done=1 tick=0 at cycle %0d, expected done=0", cyc);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_load(input int v);
    load = 1'b1;
    load_value = 8'(v);
    step();
    load = 1'b0;
  endtask

  task automatic do_start(output int e0);
    start = 1'b1;
    step();
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic pulse_stop_at(input int edge_no);
    wait_until(edge_no - 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    int e0, e1;
    bit saw_run;
    step();
    step();
    reset = 1'b0;
    step();
    check("reset_count", int'(count), 0);
    check("reset_running", int'(running), 0);
    check("reset_paused", int'(paused), 0);

    // Load 3 and run to completion.
    do_load(3);
    check("load3_count", int'(count), 3);
    check("load3_idle", int'(running), 0);
    do_start(e0);
    check("run3_running", int'(running), 1);
    push_ticks(e0 + P, 3, 3);
    wait_until(e0 + 3 * P);
    check("run3_done_running", int'(running), 0);
    check("run3_done_count", int'(count), 0);
    check("run3_done_pulse", int'(done), 1);
    step();
    check("run3_done_cleared", int'(done), 0);

    // Stop 14 edges after start, hold 50 cycles, resume.
    do_load(5);
    do_start(e0);
    push_ticks(e0 + P, 5, 1);
    pulse_stop_at(e0 + 14);
    check("pause_paused", int'(paused), 1);
    check("pause_running", int'(running), 0);
    repeat (50) step();
    check("pause_hold_count", int'(count), 4);
    check("pause_hold_paused", int'(paused), 1);
    do_start(e1);
    check("resume_running", int'(running), 1);
    push_ticks(e1 + 6, 4, 4);
    wait_until(e1 + 6 + 3 * P);
    check("resume_end_running", int'(running), 0);
    check("resume_end_count", int'(count), 0);

    // Start with count 0 is ignored.
    do_start(e0);
    saw_run = 1'b0;
    repeat (100) begin
      if (running || paused) saw_run = 1'b1;
      step();
    end
    check("zero_start_never_ran", int'(saw_run), 0);
    check("zero_start_count", int'(count), 0);

    // Reload mid-run at count 4 aborts, then a full run of 9.
    do_load(6);
    do_start(e0);
    push_ticks(e0 + P, 6, 2);
    wait_until(e0 + 24);
    check("midrun_count_before", int'(count), 4);
    do_load(9);
    check("midrun_reload_count", int'(count), 9);
    check("midrun_reload_idle", int'(running), 0);
    check("midrun_reload_done", int'(done), 0);
    do_start(e1);
    push_ticks(e1 + P, 9, 9);
    wait_until(e1 + 9 * P);
    check("reload_run_end_count", int'(count), 0);
    step();
    check("reload_run_end_running", int'(running), 0);

    // Stop on the terminal tick edge: done wins.
    do_load(2);
    do_start(e0);
    push_ticks(e0 + P, 2, 2);
    pulse_stop_at(e0 + 2 * P);
    check("stop_terminal_done", int'(done), 1);
    check("stop_terminal_count", int'(count), 0);
    check("stop_terminal_paused", int'(paused), 0);
    check("stop_terminal_running", int'(running), 0);
    step();
    check("stop_terminal_after_paused", int'(paused), 0);

    // Reset held 3 cycles mid-run.
    do_load(5);
    do_start(e0);
    push_ticks(e0 + P, 5, 1);
    wait_until(e0 + 13);
    reset = 1'b1;
    step();
    check("midreset_count", int'(count), 0);
    check("midreset_running", int'(running), 0);
    check("midreset_tick", int'(tick), 0);
    step();
    step();
    reset = 1'b0;
    step();
    check("postreset_running", int'(running), 0);
    check("postreset_paused", int'(paused), 0);
    check("postreset_count", int'(count), 0);
    repeat (20) step();

    // Load wins over a simultaneous start.
    load = 1'b1;
    start = 1'b1;
    load_value = 8'd3;
    step();
    load = 1'b0;
    start = 1'b0;
    check("load_start_count", int'(count), 3);
    check("load_start_idle", int'(running), 0);
    repeat (15) step();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
